// File: rtl/bsg_dramsim3_bw_pkg.sv
// Shared types for the DRAMSim3 bandwidth-bench requester: payload view, FSM states, write-pattern lane width.
package bsg_dramsim3_bw_pkg;

   localparam int unsigned lane_width_gp = 32;

   typedef enum logic [1:0] {
      e_idle  = 2'd0,
      e_run   = 2'd1,
      e_drain = 2'd2,
      e_done  = 2'd3
   } bw_state_e;

   // Block index is zero-extended into one pattern lane.
   typedef struct packed {
      logic                     w;
      logic [lane_width_gp-1:0] idx;
   } bw_payload_s;

endpackage

// File: rtl/bsg_counter_up_down.sv
// Up/down occupancy counter with asynchronous active-low reset.
module bsg_counter_up_down
  #(parameter int unsigned max_val_p  = 16
   ,parameter int unsigned init_val_p = 0
   )
   (input  logic                           clk_i
   ,input  logic                           reset_n_i
   ,input  logic                           up_i
   ,input  logic                           down_i
   ,output logic [$clog2(max_val_p+1)-1:0] count_o
   );

   localparam int unsigned width_lp = $clog2(max_val_p+1);

   logic [width_lp-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q + width_lp'(up_i) - width_lp'(down_i);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) count_q <= width_lp'(init_val_p);
      else            count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/bsg_dramsim3_bw_stats.sv
// Bandwidth statistics: saturating command counters, run-cycle timer and read-data XOR checksum.
module bsg_dramsim3_bw_stats
  #(parameter int unsigned ctr_width_p  = 32
   ,parameter int unsigned data_width_p = 256
   )
   (input  logic                    clk_i
   ,input  logic                    reset_n_i
   ,input  logic                    cmd_accept_i
   ,input  logic                    read_inc_i
   ,input  logic                    write_inc_i
   ,input  logic                    run_i
   ,input  logic                    rdata_v_i
   ,input  logic [data_width_p-1:0] rdata_i
   ,output logic [ctr_width_p-1:0]  cycles_o
   ,output logic [ctr_width_p-1:0]  reads_o
   ,output logic [ctr_width_p-1:0]  writes_o
   ,output logic [data_width_p-1:0] checksum_o
   );

   logic                    started_q,  started_d;
   logic [ctr_width_p-1:0]  cycles_q,   cycles_d;
   logic [ctr_width_p-1:0]  reads_q,    reads_d;
   logic [ctr_width_p-1:0]  writes_q,   writes_d;
   logic [data_width_p-1:0] checksum_q, checksum_d;

   always_comb begin
      started_d  = started_q | cmd_accept_i;
      cycles_d   = cycles_q;
      reads_d    = reads_q;
      writes_d   = writes_q;
      checksum_d = checksum_q;
      // Timer starts the cycle after the first accepted command.
      if (started_q && run_i && (cycles_q != '1))
         cycles_d = cycles_q + 1'b1;
      if (read_inc_i && (reads_q != '1))
         reads_d = reads_q + 1'b1;
      if (write_inc_i && (writes_q != '1))
         writes_d = writes_q + 1'b1;
      if (rdata_v_i)
         checksum_d = checksum_q ^ rdata_i;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         started_q  <= 1'b0;
         cycles_q   <= '0;
         reads_q    <= '0;
         writes_q   <= '0;
         checksum_q <= '0;
      end else begin
         started_q  <= started_d;
         cycles_q   <= cycles_d;
         reads_q    <= reads_d;
         writes_q   <= writes_d;
         checksum_q <= checksum_d;
      end
   end

   assign cycles_o   = cycles_q;
   assign reads_o    = reads_q;
   assign writes_o   = writes_q;
   assign checksum_o = checksum_q;

endmodule

// File: rtl/bsg_dramsim3_bw_requester.sv
// Pops trace payloads, issues DRAM read/write commands with write data, bounds outstanding reads,
// then drains and exposes bandwidth statistics.
module bsg_dramsim3_bw_requester
   import bsg_dramsim3_bw_pkg::*;
  #(parameter int unsigned payload_width_p      = 10
   ,parameter int unsigned channel_addr_width_p = 29
   ,parameter int unsigned data_width_p         = 256
   ,parameter int unsigned max_out_p            = 16
   ,parameter int unsigned ctr_width_p          = 32
   )
   (input  logic                            clk_i
   ,input  logic                            reset_n_i
   ,input  logic                            v_i
   ,input  logic [payload_width_p-1:0]      data_i
   ,output logic                            yumi_o
   ,input  logic                            trace_done_i
   ,output logic                            dram_v_o
   ,output logic                            dram_w_o
   ,output logic [channel_addr_width_p-1:0] dram_addr_o
   ,input  logic                            dram_yumi_i
   ,output logic                            dram_data_v_o
   ,output logic [data_width_p-1:0]         dram_data_o
   ,input  logic                            dram_data_yumi_i
   ,input  logic                            dram_rdata_v_i
   ,input  logic [data_width_p-1:0]         dram_rdata_i
   ,output logic                            done_o
   ,output logic [ctr_width_p-1:0]          cycles_o
   ,output logic [ctr_width_p-1:0]          reads_o
   ,output logic [ctr_width_p-1:0]          writes_o
   ,output logic [data_width_p-1:0]         checksum_o
   );

   localparam int unsigned idx_width_lp   = payload_width_p - 1;
   localparam int unsigned addr_shift_lp  = $clog2(data_width_p/8);
   localparam int unsigned lanes_lp       = data_width_p / lane_width_gp;
   localparam int unsigned out_width_lp   = $clog2(max_out_p+1);
   localparam logic [out_width_lp-1:0] max_out_lp = out_width_lp'(max_out_p);

   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_n;

   always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

   // Assert asynchronously, release on the clock.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) rst_sync_q <= '0;
      else            rst_sync_q <= rst_sync_d;
   end

   assign rst_n = rst_sync_q[1];

   bw_state_e                     state_q, state_d;
   logic                          cmd_sent_q, cmd_sent_d;
   logic                          data_sent_q, data_sent_d;
   logic                          done_q, done_d;
   bw_payload_s                   payload;
   logic [channel_addr_width_p-1:0] idx_ext;
   logic                          active, room, cmd_fire, data_fire;
   logic                          cmd_done, data_done, read_ret;
   logic [out_width_lp-1:0]       out_count;

   always_comb begin
      payload                       = '0;
      payload.w                     = data_i[payload_width_p-1];
      payload.idx[idx_width_lp-1:0] = data_i[idx_width_lp-1:0];
      idx_ext                       = '0;
      idx_ext[idx_width_lp-1:0]     = data_i[idx_width_lp-1:0];
   end

   always_comb begin
      active        = (state_q == e_run) & v_i;
      room          = (out_count < max_out_lp);
      dram_v_o      = active & ~cmd_sent_q & (payload.w | room);
      dram_w_o      = active & payload.w;
      dram_addr_o   = active ? (idx_ext << addr_shift_lp) : '0;
      dram_data_v_o = active & payload.w & ~data_sent_q;
      dram_data_o   = active ? {lanes_lp{payload.idx}} : '0;
      cmd_fire      = dram_v_o & dram_yumi_i;
      data_fire     = dram_data_v_o & dram_data_yumi_i;
      cmd_done      = cmd_sent_q | cmd_fire;
      data_done     = data_sent_q | data_fire;
      // Pop on the cycle the final handshake lands, not the one after.
      yumi_o        = active & (payload.w ? (cmd_done & data_done) : cmd_fire);
      cmd_sent_d    = yumi_o ? 1'b0 : cmd_done;
      data_sent_d   = yumi_o ? 1'b0 : data_done;
      read_ret      = dram_rdata_v_i & (out_count != '0);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         e_idle:  if (v_i | trace_done_i)  state_d = e_run;
         e_run:   if (trace_done_i & ~v_i) state_d = e_drain;
         e_drain: if (out_count == '0)     state_d = e_done;
         e_done:                           state_d = e_done;
         default:                          state_d = e_idle;
      endcase
      done_d = (state_d == e_done);
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= e_idle;
         cmd_sent_q  <= 1'b0;
         data_sent_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_sent_q  <= cmd_sent_d;
         data_sent_q <= data_sent_d;
         done_q      <= done_d;
      end
   end

   assign done_o = done_q;

   bsg_counter_up_down
     #(.max_val_p(max_out_p)
      ,.init_val_p(0)
      )
    outstanding
     (.clk_i    (clk_i)
     ,.reset_n_i(rst_n)
     ,.up_i     (cmd_fire & ~payload.w)
     ,.down_i   (read_ret)
     ,.count_o  (out_count)
     );

   always_ff @(posedge clk_i) begin
      assert (!(rst_n && dram_rdata_v_i && (out_count == '0)))
         else $error("bsg_dramsim3_bw_requester: read data returned with no read outstanding");
   end

   bsg_dramsim3_bw_stats
     #(.ctr_width_p (ctr_width_p)
      ,.data_width_p(data_width_p)
      )
    stats
     (.clk_i       (clk_i)
     ,.reset_n_i   (rst_n)
     ,.cmd_accept_i(cmd_fire)
     ,.read_inc_i  (cmd_fire & ~payload.w)
     ,.write_inc_i (cmd_fire & payload.w)
     ,.run_i       (state_q != e_done)
     ,.rdata_v_i   (read_ret)
     ,.rdata_i     (dram_rdata_i)
     ,.cycles_o    (cycles_o)
     ,.reads_o     (reads_o)
     ,.writes_o    (writes_o)
     ,.checksum_o  (checksum_o)
     );

endmodule

// File: tb/tb_bsg_dramsim3_bw_requester.sv
// Directed bench for the bandwidth requester: table-driven handshake vectors plus multi-cycle sequences.
module tb_bsg_dramsim3_bw_requester;

   localparam int PW = 10;
   localparam int AW = 29;
   localparam int DW = 256;
   localparam int MO = 16;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          v;
   logic [PW-1:0] data;
   logic          yumi_o;
   logic          trace_done;
   logic          dram_v_o, dram_w_o;
   logic [AW-1:0] dram_addr_o;
   logic          dram_yumi;
   logic          dram_data_v_o;
   logic [DW-1:0] dram_data_o;
   logic          dram_data_yumi;
   logic          rv;
   logic [DW-1:0] rdata;
   logic          done_o;
   logic [CW-1:0] cycles_o, reads_o, writes_o;
   logic [DW-1:0] checksum_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bsg_dramsim3_bw_requester
     #(.payload_width_p(PW), .channel_addr_width_p(AW), .data_width_p(DW)
      ,.max_out_p(MO), .ctr_width_p(CW))
    dut
     (.clk_i(clk), .reset_n_i(reset_n), .v_i(v), .data_i(data), .yumi_o(yumi_o)
     ,.trace_done_i(trace_done), .dram_v_o(dram_v_o), .dram_w_o(dram_w_o)
     ,.dram_addr_o(dram_addr_o), .dram_yumi_i(dram_yumi), .dram_data_v_o(dram_data_v_o)
     ,.dram_data_o(dram_data_o), .dram_data_yumi_i(dram_data_yumi), .dram_rdata_v_i(rv)
     ,.dram_rdata_i(rdata), .done_o(done_o), .cycles_o(cycles_o), .reads_o(reads_o)
     ,.writes_o(writes_o), .checksum_o(checksum_o));

   typedef struct {
      logic          v;
      logic [PW-1:0] d;
      logic          cy;
      logic          dy;
      logic          e_v;
      logic          e_w;
      logic [AW-1:0] e_addr;
      logic          e_dv;
      logic          e_y;
   } vec_t;

   vec_t          tbl [9];
   vec_t          t;
   logic [DW-1:0] cs;
   int            n, acc, pops, idx;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   function automatic logic [DW-1:0] pat(input logic [PW-2:0] i);
      logic [DW-1:0] p;
      for (int k = 0; k < DW/32; k++) p[k*32 +: 32] = {23'b0, i};
      return p;
   endfunction

   task automatic idle_inputs();
      v = 1'b0; data = '0; trace_done = 1'b0; dram_yumi = 1'b0;
      dram_data_yumi = 1'b0; rv = 1'b0; rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic wait_done(input int limit, input string name);
      int k;
      k = 0;
      while (!done_o && k < limit) begin
         tick();
         k++;
      end
      chk(name, DW'(done_o), DW'(1'b1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //            v     d        cy    dy    e_v   e_w   e_addr   e_dv  e_y
      tbl[0] = '{1'b1, 10'h207, 1'b0, 1'b0, 1'b0, 1'b0, 29'd0,   1'b0, 1'b0};
      tbl[1] = '{1'b1, 10'h207, 1'b0, 1'b1, 1'b1, 1'b1, 29'd224, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 10'h207, 1'b0, 1'b0, 1'b1, 1'b1, 29'd224, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 10'h207, 1'b0, 1'b0, 1'b1, 1'b1, 29'd224, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 10'h207, 1'b1, 1'b0, 1'b1, 1'b1, 29'd224, 1'b0, 1'b1};
      tbl[5] = '{1'b1, 10'h201, 1'b1, 1'b1, 1'b1, 1'b1, 29'd32,  1'b1, 1'b1};
      tbl[6] = '{1'b1, 10'h003, 1'b0, 1'b0, 1'b1, 1'b0, 29'd96,  1'b0, 1'b0};
      tbl[7] = '{1'b1, 10'h003, 1'b1, 1'b0, 1'b1, 1'b0, 29'd96,  1'b0, 1'b1};
      tbl[8] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 29'd0,   1'b0, 1'b0};

      // Reset values
      do_reset();
      sample();
      chk("rst_dram_v",   DW'(dram_v_o),      DW'(1'b0));
      chk("rst_yumi",     DW'(yumi_o),        DW'(1'b0));
      chk("rst_done",     DW'(done_o),        DW'(1'b0));
      chk("rst_reads",    DW'(reads_o),       DW'(0));
      chk("rst_writes",   DW'(writes_o),      DW'(0));
      chk("rst_cycles",   DW'(cycles_o),      DW'(0));
      chk("rst_checksum", checksum_o,         DW'(0));

      // Empty trace: IDLE -> RUN -> DRAIN -> DONE with zero counts
      tick(); trace_done = 1'b1;
      tick(); tick();
      chk("e_not_done", DW'(done_o), DW'(1'b0));
      tick();
      chk("e_done",   DW'(done_o),   DW'(1'b1));
      chk("e_cycles", DW'(cycles_o), DW'(0));
      chk("e_reads",  DW'(reads_o),  DW'(0));
      chk("e_writes", DW'(writes_o), DW'(0));

      // Table: write idx 7 with data accepted 3 cycles early, write idx 1 both same cycle, read idx 3
      do_reset();
      for (int i = 0; i < 9; i++) begin
         t = tbl[i];
         tick();
         v = t.v; data = t.d; dram_yumi = t.cy; dram_data_yumi = t.dy;
         sample();
         chk($sformatf("a%0d_dram_v", i),  DW'(dram_v_o),      DW'(t.e_v));
         chk($sformatf("a%0d_dram_w", i),  DW'(dram_w_o),      DW'(t.e_w));
         chk($sformatf("a%0d_addr", i),    DW'(dram_addr_o),   DW'(t.e_addr));
         chk($sformatf("a%0d_data_v", i),  DW'(dram_data_v_o), DW'(t.e_dv));
         chk($sformatf("a%0d_yumi", i),    DW'(yumi_o),        DW'(t.e_y));
         if (t.e_dv) chk($sformatf("a%0d_pattern", i), dram_data_o, pat(t.d[PW-2:0]));
      end
      tick(); rv = 1'b1; rdata = DW'(8'h5A);
      tick(); rv = 1'b0;
      sample();
      chk("a_reads",    DW'(reads_o),  DW'(1));
      chk("a_writes",   DW'(writes_o), DW'(2));
      chk("a_checksum", checksum_o,    DW'(8'h5A));
      tick(); trace_done = 1'b1;
      wait_done(10, "a_done");

      // Single read idx 3: cmd accepted on the third RUN cycle, data back 10 cycles later
      do_reset();
      v = 1'b1; data = 10'h003;
      tick(); tick(); tick();
      dram_yumi = 1'b1;
      sample();
      chk("b_issue", DW'(dram_v_o), DW'(1'b1));
      chk("b_pop",   DW'(yumi_o),   DW'(1'b1));
      tick();
      v = 1'b0; dram_yumi = 1'b0; trace_done = 1'b1;
      n = 0;
      while (n < 40 && !done_o) begin
         rv = (n == 10); rdata = DW'(8'hA5);
         if (n == 10) chk("b_not_done", DW'(done_o), DW'(1'b0));
         tick();
         n++;
      end
      rv = 1'b0;
      chk("b_done",     DW'(done_o),   DW'(1'b1));
      chk("b_cycles",   DW'(cycles_o), DW'(n));
      chk("b_cycles12", DW'(cycles_o), DW'(12));
      chk("b_reads",    DW'(reads_o),  DW'(1));
      chk("b_writes",   DW'(writes_o), DW'(0));
      chk("b_checksum", checksum_o,    DW'(8'hA5));

      // Back-to-back reads against the outstanding limit
      do_reset();
      idx = 0; acc = 0; pops = 0; cs = '0;
      v = 1'b1; data = PW'(idx); dram_yumi = 1'b1;
      for (int c = 0; c < 25; c++) begin
         sample();
         if (dram_v_o) acc++;
         if (yumi_o) begin pops++; idx++; end
         tick();
         data = PW'(idx);
      end
      sample();
      chk("c_accepted",  DW'(acc),      DW'(MO));
      chk("c_pops",      DW'(pops),     DW'(MO));
      chk("c_stall",     DW'(dram_v_o), DW'(1'b0));
      tick(); rv = 1'b1; rdata = DW'(8'h11); cs ^= rdata;
      sample();
      chk("c_ret_at_max", DW'(dram_v_o), DW'(1'b0));
      tick(); rdata = DW'(8'h22); cs ^= rdata;
      sample();
      chk("c_simul_v",    DW'(dram_v_o), DW'(1'b1));
      chk("c_simul_pop",  DW'(yumi_o),   DW'(1'b1));
      idx++;
      tick(); rv = 1'b0; data = PW'(idx);
      sample();
      chk("c_simul_hold", DW'(dram_v_o), DW'(1'b1));
      idx++;
      tick(); data = PW'(idx);
      sample();
      chk("c_full_again", DW'(dram_v_o), DW'(1'b0));
      tick(); v = 1'b0; dram_yumi = 1'b0; trace_done = 1'b1;
      for (int j = 1; j <= 15; j++) begin
         rv = 1'b1; rdata = DW'(j); cs ^= rdata;
         tick();
      end
      rv = 1'b0;
      repeat (3) tick();
      chk("c_not_done_15", DW'(done_o), DW'(1'b0));
      rv = 1'b1; rdata = DW'(16); cs ^= rdata;
      tick();
      rv = 1'b0;
      wait_done(10, "c_done");
      chk("c_reads",    DW'(reads_o), DW'(18));
      chk("c_checksum", checksum_o,   cs);

      // Reset mid-burst, then replay four reads
      do_reset();
      v = 1'b1; data = 10'h005; dram_yumi = 1'b1;
      repeat (4) tick();
      #2 reset_n = 1'b0;
      #1;
      chk("d_rst_dram_v", DW'(dram_v_o), DW'(1'b0));
      chk("d_rst_yumi",   DW'(yumi_o),   DW'(1'b0));
      chk("d_rst_reads",  DW'(reads_o),  DW'(0));
      chk("d_rst_done",   DW'(done_o),   DW'(1'b0));
      tick(); tick();
      reset_n = 1'b1; v = 1'b0; dram_yumi = 1'b0;
      repeat (3) tick();
      v = 1'b1; data = 10'h009; dram_yumi = 1'b1;
      pops = 0; n = 0;
      while (pops < 4 && n < 20) begin
         sample();
         if (yumi_o) pops++;
         tick();
         n++;
         if (pops == 4) begin v = 1'b0; dram_yumi = 1'b0; end
      end
      chk("d_pops", DW'(pops), DW'(4));
      v = 1'b0; dram_yumi = 1'b0; trace_done = 1'b1;
      rv = 1'b1; rdata = '0;
      repeat (4) tick();
      rv = 1'b0;
      wait_done(10, "d_done");
      chk("d_reads", DW'(reads_o), DW'(4));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
